// File: rtl/timer_pkg.sv
// Shared definitions for the interval sequencer and its auto-reload timer:
// FSM state encoding, default geometry and the reset interval value.
package timer_pkg;

   localparam int unsigned DEF_WIDTH      = 32'd16;
   localparam int unsigned DEF_DEPTH      = 32'd8;
   localparam int unsigned RESET_INTERVAL = 32'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/auto_reload_timer.sv
// Auto-reload countdown timer. The count holds the number of cycles left in the
// current interval; done marks the final cycle, on which the next interval
// length is taken from load_value without a gap cycle.
module auto_reload_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reload,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   localparam logic [WIDTH-1:0] RST_VAL    = WIDTH'(RESET_INTERVAL);
   localparam logic [WIDTH-1:0] LAST_CYCLE = WIDTH'(1);
   localparam logic [WIDTH-1:0] DEC_STEP   = WIDTH'(1);

   logic [WIDTH-1:0] cnt_r;
   logic             done_s;

   // Interval expires on the cycle the count reaches its last cycle.
   always_comb begin
      done_s = (cnt_r == LAST_CYCLE);
   end

   // Count down; load a fresh interval on request or on expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= RST_VAL;
      end else if (reload || done_s) begin
         cnt_r <= load_value;
      end else begin
         cnt_r <= cnt_r - DEC_STEP;
      end
   end

   assign done = done_s;

endmodule

// File: rtl/interval_sequencer.sv
// Interval sequencer: walks a table of interval lengths through one shared
// auto-reload timer, emitting a tick (with entry index) per expired interval.
// Supports one-pass or looping sequences and a synchronous stop.
module interval_sequencer
   import timer_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic [IDX_W-1:0] cfg_last,
   input  logic             loop_en,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             tick,
   output logic [IDX_W-1:0] tick_idx,
   output logic             seq_done,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_INTERVAL);
   localparam logic [WIDTH-1:0] ZERO_VAL  = {WIDTH{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   seq_state_t       state_r;
   seq_state_t       state_s;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] ptr_s;
   logic [IDX_W-1:0] last_r;
   logic [IDX_W-1:0] last_s;
   logic             loop_r;
   logic             loop_s;
   logic [IDX_W-1:0] nxt_s;
   logic [WIDTH-1:0] table_r [DEPTH];
   logic             cfg_err_r;
   logic             reload_s;
   logic [WIDTH-1:0] load_value_s;
   logic             timer_done_s;
   logic             tick_s;
   logic             seq_done_s;
   logic             final_s;

   // Entry following cur; wraps to 0 after the final entry by direct compare,
   // so entries beyond the final one are never visited.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur,
                                                 input logic [IDX_W-1:0] lst);
      logic [IDX_W-1:0] res;
      if (cur == lst) begin
         res = IDX_ZERO;
      end else begin
         res = cur + IDX_ONE;
      end
      return res;
   endfunction

   // Interval table: zero is clamped to one, writes during a sequence are refused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_r[i] <= RST_VAL;
         end
         cfg_err_r <= 1'b0;
      end else begin
         cfg_err_r <= 1'b0;
         if (cfg_we) begin
            if (state_r != ST_IDLE) begin
               cfg_err_r <= 1'b1;
            end else if (cfg_data == ZERO_VAL) begin
               table_r[cfg_addr] <= RST_VAL;
               cfg_err_r         <= 1'b1;
            end else begin
               table_r[cfg_addr] <= cfg_data;
            end
         end
      end
   end

   // Next-state, pointer advance and timer control.
   always_comb begin
      state_s      = state_r;
      ptr_s        = ptr_r;
      last_s       = last_r;
      loop_s       = loop_r;
      nxt_s        = next_idx(ptr_r, last_r);
      reload_s     = 1'b1;
      load_value_s = table_r[IDX_ZERO];
      tick_s       = 1'b0;
      seq_done_s   = 1'b0;
      final_s      = (ptr_r == last_r) && !loop_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !stop) begin
               state_s = ST_ARM;
               last_s  = cfg_last;
               loop_s  = loop_en;
               ptr_s   = IDX_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            reload_s     = 1'b1;
            load_value_s = table_r[IDX_ZERO];
            if (stop) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_RUN: begin
            reload_s     = 1'b0;
            load_value_s = table_r[nxt_s];
            tick_s       = timer_done_s;
            if (timer_done_s) begin
               ptr_s      = nxt_s;
               seq_done_s = final_s;
            end else begin
               ptr_s      = ptr_r;
               seq_done_s = 1'b0;
            end
            if (stop) begin
               state_s = ST_IDLE;
            end else if (timer_done_s && final_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and run parameters latched at start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         ptr_r   <= IDX_ZERO;
         last_r  <= IDX_ZERO;
         loop_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         last_r  <= last_s;
         loop_r  <= loop_s;
      end
   end

   auto_reload_timer #(
      .WIDTH (WIDTH)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .reload     (reload_s),
      .load_value (load_value_s),
      .done       (timer_done_s)
   );

   assign busy     = (state_r != ST_IDLE);
   assign tick     = tick_s;
   assign tick_idx = ptr_r;
   assign seq_done = seq_done_s;
   assign cfg_err  = cfg_err_r;

endmodule
